ultrasonic_ranger_ctrl: RTL and testbench

Measurement sequencer for the HC-SR04-style ultrasonic sensor that feeds the inches conversion and display path. It issues periodic trigger pulses and synchronises the asynchronous echo input. It measures the echo-high width in clock ticks and presents `echo_width` with a one-cycle valid strobe. On a missing or overlong echo it reports a saturated width, so downstream logic reads "far / ground".

---
 rtl/ultrasonic_ranger_ctrl_pkg.sv | 24 ++
 rtl/ultrasonic_ranger_ctrl_if.sv | 17 +
 rtl/ultrasonic_ranger_ctrl_echo_sync.sv | 21 ++
 rtl/ultrasonic_ranger_ctrl.sv | 152 +++++++++++++++
 tb/tb_ultrasonic_ranger_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/ultrasonic_ranger_ctrl_pkg.sv
// Shared types and tick constants for the ultrasonic ranger sequencer.
// Default tick counts are derived from the nominal 12 MHz system clock.
package ultrasonic_pkg;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  function automatic int unsigned us_to_ticks(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // A full period must fit the trigger plus worst-case wait and worst-case echo.
  function automatic bit period_legal(input int unsigned trig_ticks,
                                      input int unsigned timeout_ticks,
                                      input int unsigned period_ticks);
    return longint'(period_ticks) >=
           longint'(trig_ticks) + 64'd2 * longint'(timeout_ticks) + 64'd4;
  endfunction

  localparam int unsigned DEF_CLK_FREQ_HZ        = 12_000_000;
  localparam int unsigned DEF_TRIG_TICKS         = us_to_ticks(DEF_CLK_FREQ_HZ, 10);
  localparam int unsigned DEF_ECHO_TIMEOUT_TICKS = us_to_ticks(DEF_CLK_FREQ_HZ, 30_000);
  localparam int unsigned DEF_PERIOD_TICKS       = us_to_ticks(DEF_CLK_FREQ_HZ, 70_000);

endpackage

// File: rtl/ultrasonic_ranger_ctrl_if.sv
// Sensor/host-facing signal bundle of the ranger. The slave side is the
// controller; the master side drives enable and the raw echo.
interface ultrasonic_ranger_ctrl_if;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [31:0] echo_width;
  logic        echo_valid;
  logic        timeout;
  logic        stuck;
  logic        busy;

  modport master (output enable, echo,
                  input  trig, echo_width, echo_valid, timeout, stuck, busy);
  modport slave  (input  enable, echo,
                  output trig, echo_width, echo_valid, timeout, stuck, busy);
endinterface

// File: rtl/ultrasonic_ranger_ctrl_echo_sync.sv
// Two-flop synchroniser for the asynchronous echo line, plus single-cycle
// rise/fall detection on the synchronised level.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);
  // sh[0], sh[1]: metastability chain; sh[2]: previous synchronised level
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], echo};

  assign echo_s = sh[1];
  assign rise   = sh[1] & ~sh[2];
  assign fall   = ~sh[1] & sh[2];
endmodule

// File: rtl/ultrasonic_ranger_ctrl.sv
// Periodic trigger / echo-width measurement sequencer for an HC-SR04-style
// sensor; missing or overlong echoes report a saturated width with timeout.
module ultrasonic_ranger_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ        = DEF_CLK_FREQ_HZ,
  parameter int unsigned TRIG_TICKS         = us_to_ticks(CLK_FREQ_HZ, 10),
  parameter int unsigned ECHO_TIMEOUT_TICKS = us_to_ticks(CLK_FREQ_HZ, 30_000),
  parameter int unsigned PERIOD_TICKS       = us_to_ticks(CLK_FREQ_HZ, 70_000)
) (
  input logic                      clk,
  input logic                      rst_n,
  ultrasonic_ranger_ctrl_if.slave  bus
);

  generate
    if (!period_legal(TRIG_TICKS, ECHO_TIMEOUT_TICKS, PERIOD_TICKS)) begin : g_bad_period
      $error("PERIOD_TICKS must be >= TRIG_TICKS + 2*ECHO_TIMEOUT_TICKS + 4");
    end
  endgenerate

  localparam logic [31:0] TRIG_LAST   = TRIG_TICKS - 1;
  localparam logic [31:0] WAIT_LAST   = ECHO_TIMEOUT_TICKS - 1;
  localparam logic [31:0] WIDTH_MAX   = ECHO_TIMEOUT_TICKS;
  localparam logic [31:0] PERIOD_LAST = PERIOD_TICKS - 1;

  logic echo_s, rise, fall;

  echo_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .echo   (bus.echo),
    .echo_s (echo_s),
    .rise   (rise),
    .fall   (fall)
  );

  state_t      state;
  logic [31:0] phase_cnt;   // trigger length in TRIG, rise wait in WAIT_RISE
  logic [31:0] width_cnt;
  logic [31:0] period_cnt;
  logic        trig, echo_valid, timeout, stuck, busy;
  logic [31:0] echo_width;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      width_cnt  <= '0;
      period_cnt <= '0;
      trig       <= 1'b0;
      echo_width <= '0;
      echo_valid <= 1'b0;
      timeout    <= 1'b0;
      stuck      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      echo_valid <= 1'b0;
      if (state != IDLE && period_cnt != PERIOD_LAST)
        period_cnt <= period_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (echo_s) begin
              stuck <= 1'b1;
            end else begin
              state      <= TRIG;
              trig       <= 1'b1;
              stuck      <= 1'b0;
              busy       <= 1'b1;
              phase_cnt  <= '0;
              period_cnt <= '0;
            end
          end
        end

        TRIG: begin
          if (phase_cnt == TRIG_LAST) begin
            state     <= WAIT_RISE;
            trig      <= 1'b0;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        WAIT_RISE: begin
          if (rise) begin
            state     <= MEASURE;
            width_cnt <= 32'd1;
          end else if (phase_cnt == WAIT_LAST) begin
            state      <= HOLDOFF;
            echo_width <= WIDTH_MAX;
            timeout    <= 1'b1;
            echo_valid <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        MEASURE: begin
          if (fall) begin
            state      <= HOLDOFF;
            echo_width <= width_cnt;
            timeout    <= 1'b0;
            echo_valid <= 1'b1;
          end else if (echo_s && width_cnt == WIDTH_MAX) begin
            // Saturated: report now; the eventual fall is ignored in HOLDOFF.
            state      <= HOLDOFF;
            echo_width <= WIDTH_MAX;
            timeout    <= 1'b1;
            echo_valid <= 1'b1;
          end else if (echo_s) begin
            width_cnt <= width_cnt + 32'd1;
          end
        end

        HOLDOFF: begin
          if (period_cnt == PERIOD_LAST) begin
            if (!bus.enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (echo_s) begin
              stuck <= 1'b1;
            end else begin
              state      <= TRIG;
              trig       <= 1'b1;
              stuck      <= 1'b0;
              phase_cnt  <= '0;
              period_cnt <= '0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          trig  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig       = trig;
  assign bus.echo_width = echo_width;
  assign bus.echo_valid = echo_valid;
  assign bus.timeout    = timeout;
  assign bus.stuck      = stuck;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed-plus-random bench: echo pulses are scheduled in absolute cycles and
// the expected trigger/valid timeline is computed arithmetically from them.
module tb_ultrasonic_ranger_ctrl;
  localparam int unsigned TT = 4, TO = 50, PT = 120;

  typedef struct {
    int unsigned cyc;
    int unsigned width;
    bit          to;
  } val_t;

  logic clk = 1'b0;
  logic rst_n;
  ultrasonic_ranger_ctrl_if bus();

  ultrasonic_ranger_ctrl #(
    .CLK_FREQ_HZ        (12_000_000),
    .TRIG_TICKS         (TT),
    .ECHO_TIMEOUT_TICKS (TO),
    .PERIOD_TICKS       (PT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned rise_q[$], fall_q[$], exp_rise[$], exp_fall[$];
  val_t        val_q[$], exp_val[$];
  logic        trig_d = 1'b0;

  // Event log sampled mid-cycle; cyc is the number of the edge just passed.
  always @(negedge clk) begin
    if (bus.trig === 1'b1 && trig_d !== 1'b1) rise_q.push_back(cyc);
    if (bus.trig !== 1'b1 && trig_d === 1'b1) fall_q.push_back(cyc);
    trig_d = bus.trig;
    if (bus.echo_valid === 1'b1) val_q.push_back('{cyc, bus.echo_width, bus.timeout});
  end

  int unsigned n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_period(input int unsigned r);
    exp_rise.push_back(r);
    exp_fall.push_back(r + TT);
  endtask

  int unsigned r, d, h;

  initial begin
    bus.enable = 1'b0;
    bus.echo   = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    goto(3);
    chk("rst_trig",  bus.trig, 0);
    chk("rst_width", bus.echo_width, 0);
    chk("rst_valid", bus.echo_valid, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_stuck", bus.stuck, 0);
    chk("rst_busy",  bus.busy, 0);
    rst_n = 1'b1;

    goto(5);
    bus.enable = 1'b1;
    r = 6;

    // Normal echoes: width equals raw high length, valid 3 edges after raw fall.
    for (int p = 0; p < 4; p++) begin
      d = (p == 0) ? 10 : $urandom_range(40, 0);
      h = (p == 0) ? 20 : (p == 1) ? TO : (p == 2) ? 1 : $urandom_range(TO - 1, 2);
      exp_period(r);
      goto(r + TT + d);     bus.echo = 1'b1;
      goto(r + TT + d + h); bus.echo = 1'b0;
      exp_val.push_back('{r + TT + 3 + d + h, h, 1'b0});
      r += PT;
    end

    // No echo: saturated report TO cycles after the trigger ends.
    for (int p = 0; p < 2; p++) begin
      exp_period(r);
      exp_val.push_back('{r + TT + TO, TO, 1'b1});
      r += PT;
    end

    // Overlong echo: one saturated report, nothing on the late fall.
    exp_period(r);
    d = $urandom_range(10, 0);
    goto(r + TT + d);      bus.echo = 1'b1;
    goto(r + TT + d + 80); bus.echo = 1'b0;
    exp_val.push_back('{r + TT + 1 + d + 2 + TO, TO, 1'b1});
    r += PT;

    // Stuck echo: high across the period boundary until cycle 150.
    exp_period(r);
    goto(r + 9); bus.echo = 1'b1;
    exp_val.push_back('{r + 10 + 2 + TO, TO, 1'b1});
    goto(r + PT - 1);
    chk("stuck_before", bus.stuck, 0);
    goto(r + PT);
    chk("stuck_set", bus.stuck, 1);
    chk("width_held", bus.echo_width, TO);
    goto(r + 150); bus.echo = 1'b0;
    goto(r + 152);
    chk("stuck_no_trig", bus.trig, 0);
    chk("stuck_still", bus.stuck, 1);
    goto(r + 153);
    chk("stuck_trig", bus.trig, 1);
    chk("stuck_clear", bus.stuck, 0);
    r += 153;

    // Enable drop mid-measurement: report completes, then back to IDLE.
    exp_period(r);
    d = $urandom_range(30, 0);
    goto(r + TT + d);      bus.echo = 1'b1;
    goto(r + TT + d + 8);  bus.enable = 1'b0;
    goto(r + TT + d + 15); bus.echo = 1'b0;
    exp_val.push_back('{r + TT + 3 + d + 15, 15, 1'b0});
    goto(r + PT - 1);
    chk("busy_hold", bus.busy, 1);
    goto(r + PT);
    chk("busy_drop", bus.busy, 0);
    chk("idle_trig", bus.trig, 0);
    goto(r + 140);
    bus.enable = 1'b1;
    r += 141;

    // Reset in the middle of a trigger pulse.
    exp_rise.push_back(r);
    exp_fall.push_back(r + 2);
    goto(r + 2);
    chk("pre_rst_trig", bus.trig, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_trig",  bus.trig, 0);
    chk("arst_busy",  bus.busy, 0);
    chk("arst_width", bus.echo_width, 0);
    chk("arst_timeout", bus.timeout, 0);
    chk("arst_stuck", bus.stuck, 0);
    chk("arst_valid", bus.echo_valid, 0);
    goto(r + 5);
    rst_n = 1'b1;
    r += 6;
    exp_period(r);
    exp_val.push_back('{r + TT + TO, TO, 1'b1});
    goto(r + 60);
    bus.enable = 1'b0;
    goto(r + PT + 10);

    chk("n_trig_rise", rise_q.size(), exp_rise.size());
    for (int i = 0; i < rise_q.size() && i < exp_rise.size(); i++)
      chk("trig_rise_cyc", rise_q[i], exp_rise[i]);
    chk("n_trig_fall", fall_q.size(), exp_fall.size());
    for (int i = 0; i < fall_q.size() && i < exp_fall.size(); i++)
      chk("trig_fall_cyc", fall_q[i], exp_fall[i]);
    chk("n_valid", val_q.size(), exp_val.size());
    for (int i = 0; i < val_q.size() && i < exp_val.size(); i++) begin
      chk("valid_cyc",   val_q[i].cyc,   exp_val[i].cyc);
      chk("valid_width", val_q[i].width, exp_val[i].width);
      chk("valid_to",    val_q[i].to,    exp_val[i].to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
